histogram_param: RTL and testbench
==================================

# histogram_param

Parametrised histogram engine with `ap_start`/`ap_done` block-level control. Streams `N_IN` samples from an external ROM-style port A and bins them into an internal count RAM with saturating or wrapping counters. It then dumps all bins to an external RAM-style port B. It is the generalised successor of the fixed 256×8-bit histogram core: width, depth, count width, overflow policy and accumulate-across-runs mode are all configurable.

## Interface
- `N_IN`, default 256: samples per run; must be ≥ 1.
- `DATA_W`, default 8: sample width, which is also the bin index width; `NBINS = 2**DATA_W`.
- `COUNT_W`, default 32: bin counter width; must be ≥ 2.
- `SATURATE`, default 1: 1 = counts clamp at 2^COUNT_W−1; 0 = counts wrap modulo 2^COUNT_W.
- `CLEAR_ON_START`, default 1: 1 = bins zeroed every run; 0 = bins accumulate across runs.

Ports:
- `ap_clk` in 1: the single clock.
- `ap_rst` in 1: reset, synchronous and active-high.
- `ap_start` in 1: run request.
- `ap_done` out 1: one-cycle pulse at the end of a run.
- `ap_idle` out 1: high while in IDLE.
- `ap_ready` out 1: one-cycle pulse, coincident with `ap_done`.
- `A_address0` out clog2(N_IN): sample address.
- `A_ce0` out 1: sample read enable.
- `A_q0` in DATA_W: sample data, valid 1 cycle after `A_ce0`.
- `B_address0` out DATA_W: bin address.
- `B_ce0` out 1: bin write enable.
- `B_we0` out 1: bin write enable.
- `B_d0` out COUNT_W: bin count.
- `ovf` out 1: high in the `ap_done` cycle and held until the next accepted start if any bin clamped or wrapped during this run.

## Operation
- States are IDLE, CLEAR, READ, DRAIN, DUMP, DONE.
- **IDLE**: `ap_idle`=1. `ap_start`=1 → next cycle enter CLEAR if a clear is needed, else READ.
  - A clear is needed if `CLEAR_ON_START`=1 or this is the first run since reset. Bin contents are undefined after reset, so the first run always clears.
  - `ap_start` outside IDLE is ignored.
- **CLEAR**: writes 0 to bins 0..NBINS−1, one per cycle, then enters READ.
- **READ**: issues `A_ce0`=1 with `A_address0`=i for i=0..N_IN−1, one per cycle, then enters DRAIN.
- **Increment pipeline**: three stages.
  - S1: address issued.
  - S2: `A_q0` captured and bin read issued.
  - S3: count read, incremented, written back.
- **Forwarding**: the S3 write result is forwarded to the S2 read of the same bin. Back-to-back identical samples must count exactly; no stalls.
- **DRAIN**: 2 cycles to empty the pipeline, then enter DUMP.
- **DUMP**: for b=0..NBINS−1, one per cycle:
  - `B_ce0`=`B_we0`=1, `B_address0`=b, `B_d0`=count[b].
- **DONE**: `ap_done`=`ap_ready`=1 for 1 cycle, then return to IDLE.
- **Arithmetic**:
  - SATURATE=1: if count==2^COUNT_W−1, count stays and `ovf` is set.
  - SATURATE=0: count+1 mod 2^COUNT_W; `ovf` is set on wrap.
  - `ovf` clears on an accepted start.

## Timing
- **Reset values**:
  - All control outputs are 0 except `ap_idle`=1.
  - `A_address0`, `B_address0`, `B_d0` and `ovf` are 0.
  - State goes to IDLE and the first-run flag is set.
- **Reset mid-run**: aborts on the next edge, with no further A/B strobes, and the outputs take their reset values.
- **Latency**: `ap_start` sampled in cycle c0 gives `ap_done` in cycle c0 + 1 + C + N_IN + 2 + NBINS, where C = NBINS if clearing, else 0.
  - Defaults with clear: 771 cycles after c0.
- **Strobes**: `A_ce0` is high for exactly N_IN consecutive cycles per run; `B_we0` is high for exactly NBINS consecutive cycles.
- **Back-to-back runs**: `ap_start` held high re-starts in the cycle after DONE, because IDLE is entered for 1 cycle.

## Structure
- **Shared package `histogram_pkg`**:
  - State enum `hist_state_t`.
  - Sample/count typedefs parametrised via localparams at instantiation.
  - `DRAIN_CYCLES`=2.
- **Sub-module `histogram_bin_ram`**: NBINS×COUNT_W simple dual-port RAM with 1 write port, 1 read port and 1-cycle read latency.
  - Read-during-write to the same address returns old data, so forwarding lives in the top level.
- **Top level** holds the FSM, address counters, increment pipeline, forwarding and overflow logic.

## Test plan
- **Defaults, A[i]=i mod 256, N_IN=256**: every B[b]=1; `ap_done` at c0+771; `ovf`=0.
- **All-same burst, A[i]=8'h2A for all i**: B[42]=256 and every other bin 0. This checks forwarding on consecutive hits.
- **Saturation, COUNT_W=4, SATURATE=1, 20 samples of 5**: B[5]=15, `ovf`=1.
  - The same stimulus with SATURATE=0 gives B[5]=4, `ovf`=1.
- **Accumulate, CLEAR_ON_START=0, two runs of A[i]=i**:
  - Run 1 clears because it is the first after reset: all bins 1, latency 771.
  - Run 2: all bins 2, latency 515.
- **Reset mid-READ at i=100, then start**: no A/B strobes after reset and outputs take their reset values. The next run clears (latency 771) and its results are correct.
- **`ap_start` pulsed during DUMP**: ignored; exactly one `ap_done`; no extra A reads.

Source files
------------

// File: rtl/histogram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | histogram_pkg                                                              |
// | Shared state encoding and sizing helpers for the histogram engine.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package histogram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DUMP  = 3'd4,
        ST_DONE  = 3'd5
    } hist_state_t;

    localparam int DRAIN_CYCLES = 2;

    // Address width that never collapses to zero bits for a single-entry space.
    function automatic int hist_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/histogram_bin_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | histogram_bin_ram                                                          |
// | Simple dual-port bin RAM, 1-cycle read, read-during-write returns old data.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module histogram_bin_ram
    import histogram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/histogram_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | histogram_param                                                            |
// | Streams N_IN samples from port A into a bin RAM, then dumps bins to port B.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module histogram_param
    import histogram_pkg::*;
#(
    parameter int N_IN           = 256,
    parameter int DATA_W         = 8,
    parameter int COUNT_W        = 32,
    parameter int SATURATE       = 1,
    parameter int CLEAR_ON_START = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ap_start,
    output logic                         ap_done,
    output logic                         ap_idle,
    output logic                         ap_ready,
    output logic [hist_addr_w(N_IN)-1:0] A_address0,
    output logic                         A_ce0,
    input  logic [DATA_W-1:0]            A_q0,
    output logic [DATA_W-1:0]            B_address0,
    output logic                         B_ce0,
    output logic                         B_we0,
    output logic [COUNT_W-1:0]           B_d0,
    output logic                         ovf
);

    localparam int c_aw      = hist_addr_w(N_IN);
    localparam int c_drain_w = hist_addr_w(DRAIN_CYCLES);

    typedef logic [DATA_W-1:0]    sample_t;
    typedef logic [COUNT_W-1:0]   count_t;
    typedef logic [c_aw-1:0]      addr_t;
    typedef logic [c_drain_w-1:0] drain_t;

    localparam count_t c_count_max = '1;
    localparam addr_t  c_last_addr = addr_t'(N_IN - 1);
    localparam drain_t c_drain_end = drain_t'(DRAIN_CYCLES - 1);

    hist_state_t r_state;
    logic        r_first_run;
    logic        r_idle;
    logic        r_done;
    logic        r_a_ce;
    addr_t       r_a_addr;
    logic        r_b_we;
    sample_t     r_b_addr;
    sample_t     r_clr_bin;
    drain_t      r_drain;
    logic        r_ovf;
    logic        r_ovf_any;

    logic        r_s2_valid;
    logic        r_s3_valid;
    sample_t     r_s3_bin;
    logic        r_fwd_hit;
    count_t      r_fwd_data;

    sample_t     w_rd_addr;
    count_t      w_ram_q;
    count_t      w_cur;
    count_t      w_next;
    logic        w_at_max;
    logic        w_ovf_evt;
    logic        w_ram_we;
    sample_t     w_ram_waddr;
    count_t      w_ram_wdata;

    // One read port serves both the increment pipeline (S2) and the dump, which
    // reads one bin ahead so the RAM latency lines up with the B strobe.
    always_comb begin
        w_rd_addr = '0;
        if (r_s2_valid) begin
            w_rd_addr = A_q0;
        end else if (r_state == ST_DUMP) begin
            w_rd_addr = r_b_addr + sample_t'(1);
        end
        w_cur       = r_fwd_hit ? r_fwd_data : w_ram_q;
        w_at_max    = (w_cur == c_count_max);
        w_next      = (w_at_max && (SATURATE != 0)) ? w_cur : w_cur + count_t'(1);
        w_ovf_evt   = r_s3_valid && w_at_max;
        w_ram_we    = (r_state == ST_CLEAR) || r_s3_valid;
        w_ram_waddr = (r_state == ST_CLEAR) ? r_clr_bin : r_s3_bin;
        w_ram_wdata = (r_state == ST_CLEAR) ? '0 : w_next;
    end

    histogram_bin_ram #(
        .ADDR_W (DATA_W),
        .DATA_W (COUNT_W)
    ) u_bin_ram (
        .clk     (ap_clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    // The RAM read issued alongside an S3 write to the same bin would see the
    // stale value, so the freshly written count is captured for the next cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_bin   <= '0;
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_s2_valid <= r_a_ce;
            r_s3_valid <= r_s2_valid;
            r_s3_bin   <= A_q0;
            r_fwd_hit  <= r_s3_valid && (w_rd_addr == r_s3_bin);
            r_fwd_data <= w_next;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= ST_IDLE;
            r_first_run <= 1'b1;
            r_idle      <= 1'b1;
            r_done      <= 1'b0;
            r_a_ce      <= 1'b0;
            r_a_addr    <= '0;
            r_b_we      <= 1'b0;
            r_b_addr    <= '0;
            r_clr_bin   <= '0;
            r_drain     <= '0;
            r_ovf       <= 1'b0;
            r_ovf_any   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_a_ce <= 1'b0;
            r_b_we <= 1'b0;
            r_idle <= 1'b0;
            if (w_ovf_evt) begin
                r_ovf_any <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_ovf       <= 1'b0;
                        r_ovf_any   <= 1'b0;
                        r_first_run <= 1'b0;
                        // Bin contents are undefined after reset, so accumulate
                        // mode still clears on its first run.
                        if ((CLEAR_ON_START != 0) || r_first_run) begin
                            r_state   <= ST_CLEAR;
                            r_clr_bin <= '0;
                        end else begin
                            r_state  <= ST_READ;
                            r_a_ce   <= 1'b1;
                            r_a_addr <= '0;
                        end
                    end else begin
                        r_idle <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_clr_bin <= r_clr_bin + sample_t'(1);
                    if (r_clr_bin == '1) begin
                        r_state  <= ST_READ;
                        r_a_ce   <= 1'b1;
                        r_a_addr <= '0;
                    end
                end
                ST_READ: begin
                    if (r_a_addr == c_last_addr) begin
                        r_state <= ST_DRAIN;
                        r_drain <= '0;
                    end else begin
                        r_a_ce   <= 1'b1;
                        r_a_addr <= r_a_addr + addr_t'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == c_drain_end) begin
                        r_state  <= ST_DUMP;
                        r_b_we   <= 1'b1;
                        r_b_addr <= '0;
                    end else begin
                        r_drain <= r_drain + drain_t'(1);
                    end
                end
                ST_DUMP: begin
                    if (r_b_addr == '1) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_ovf   <= r_ovf_any;
                    end else begin
                        r_b_we   <= 1'b1;
                        r_b_addr <= r_b_addr + sample_t'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_idle  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

    assign ap_done    = r_done;
    assign ap_ready   = r_done;
    assign ap_idle    = r_idle;
    assign A_ce0      = r_a_ce;
    assign A_address0 = r_a_addr;
    assign B_ce0      = r_b_we;
    assign B_we0      = r_b_we;
    assign B_address0 = r_b_addr;
    assign B_d0       = r_b_we ? w_cur : '0;
    assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_histogram_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_histogram_param                                                         |
// | Directed table-driven bench over four parameterisations of the engine.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_histogram_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start    [4];
    logic        done_w   [4];
    logic        idle_w   [4];
    logic        ready_w  [4];
    logic        ace_w    [4];
    logic        bce_w    [4];
    logic        bwe_w    [4];
    logic        ovf_w    [4];
    logic [7:0]  aaddr_w  [4];
    logic [7:0]  baddr_w  [4];
    logic [31:0] bd_w     [4];
    logic [7:0]  aq       [4];
    logic [4:0]  aaddr_1, aaddr_2;
    logic [3:0]  bd_1, bd_2;

    assign aaddr_w[1] = {3'b000, aaddr_1};
    assign aaddr_w[2] = {3'b000, aaddr_2};
    assign bd_w[1]    = {28'd0, bd_1};
    assign bd_w[2]    = {28'd0, bd_2};

    histogram_param u_dut0 (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start[0]), .ap_done(done_w[0]),
        .ap_idle(idle_w[0]), .ap_ready(ready_w[0]), .A_address0(aaddr_w[0]),
        .A_ce0(ace_w[0]), .A_q0(aq[0]), .B_address0(baddr_w[0]), .B_ce0(bce_w[0]),
        .B_we0(bwe_w[0]), .B_d0(bd_w[0]), .ovf(ovf_w[0])
    );

    histogram_param #(.N_IN(20), .COUNT_W(4), .SATURATE(1)) u_sat (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start[1]), .ap_done(done_w[1]),
        .ap_idle(idle_w[1]), .ap_ready(ready_w[1]), .A_address0(aaddr_1),
        .A_ce0(ace_w[1]), .A_q0(aq[1]), .B_address0(baddr_w[1]), .B_ce0(bce_w[1]),
        .B_we0(bwe_w[1]), .B_d0(bd_1), .ovf(ovf_w[1])
    );

    histogram_param #(.N_IN(20), .COUNT_W(4), .SATURATE(0)) u_wrap (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start[2]), .ap_done(done_w[2]),
        .ap_idle(idle_w[2]), .ap_ready(ready_w[2]), .A_address0(aaddr_2),
        .A_ce0(ace_w[2]), .A_q0(aq[2]), .B_address0(baddr_w[2]), .B_ce0(bce_w[2]),
        .B_we0(bwe_w[2]), .B_d0(bd_2), .ovf(ovf_w[2])
    );

    histogram_param #(.CLEAR_ON_START(0)) u_acc (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start[3]), .ap_done(done_w[3]),
        .ap_idle(idle_w[3]), .ap_ready(ready_w[3]), .A_address0(aaddr_w[3]),
        .A_ce0(ace_w[3]), .A_q0(aq[3]), .B_address0(baddr_w[3]), .B_ce0(bce_w[3]),
        .B_we0(bwe_w[3]), .B_d0(bd_w[3]), .ovf(ovf_w[3])
    );

    // ROM-style sample source: data one cycle after the read enable.
    logic [7:0] rom [4][256];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ace_w[k]) aq[k] <= rom[k][aaddr_w[k]];
        end
    end

    // Strobe monitor and B-port capture, sampled on the falling edge.
    int          a_cnt[4], b_cnt[4], d_cnt[4], a_err[4], b_err[4], r_err[4];
    int          a_idx[4], b_idx[4], done_cyc[4];
    logic        ovf_at_done[4];
    logic [31:0] bmem [4][256];

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ace_w[k]) begin
                if (int'(aaddr_w[k]) != a_idx[k]) a_err[k]++;
                a_idx[k]++;
                a_cnt[k]++;
            end else begin
                a_idx[k] = 0;
            end
            if (bwe_w[k]) begin
                if (bce_w[k] !== 1'b1 || int'(baddr_w[k]) != b_idx[k]) b_err[k]++;
                bmem[k][baddr_w[k]] = bd_w[k];
                b_idx[k]++;
                b_cnt[k]++;
            end else begin
                b_idx[k] = 0;
            end
            if (done_w[k] !== ready_w[k]) r_err[k]++;
            if (done_w[k]) begin
                d_cnt[k]++;
                done_cyc[k]    = cyc;
                ovf_at_done[k] = ovf_w[k];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // pat 0: A[i]=i, pat 1: all 8'h2A, pat 2: all 8'h05
    task automatic load_rom(input int k, input int pat);
        for (int i = 0; i < 256; i++) begin
            case (pat)
                0:       rom[k][i] = 8'(i);
                1:       rom[k][i] = 8'h2A;
                default: rom[k][i] = 8'h05;
            endcase
        end
    endtask

    typedef struct {
        int inst;
        int pat;
        int n_in;
        int lat;
        int ovf;
        int hot;
        int hot_val;
        int other;
    } test_vec_t;

    test_vec_t vecs[6];

    task automatic run_check(input test_vec_t v);
        int k, base_a, base_b, base_d, base_ae, base_be, base_re, c0, waited;
        logic [31:0] exp;
        k       = v.inst;
        base_a  = a_cnt[k];
        base_b  = b_cnt[k];
        base_d  = d_cnt[k];
        base_ae = a_err[k];
        base_be = b_err[k];
        base_re = r_err[k];
        load_rom(k, v.pat);
        @(negedge clk);
        start[k] = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start[k] = 1'b0;
        check("ovf_clear_on_start", ovf_w[k], 0);
        waited = 0;
        while (d_cnt[k] == base_d && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        check("done_seen", d_cnt[k] - base_d, 1);
        check("latency", done_cyc[k] - c0, v.lat);
        check("ovf_at_done", ovf_at_done[k], v.ovf);
        repeat (5) @(posedge clk);
        #1;
        check("ovf_held", ovf_w[k], v.ovf);
        check("idle_after", idle_w[k], 1);
        check("single_done", d_cnt[k] - base_d, 1);
        check("a_strobes", a_cnt[k] - base_a, v.n_in);
        check("b_strobes", b_cnt[k] - base_b, 256);
        check("a_order", a_err[k] - base_ae, 0);
        check("b_order", b_err[k] - base_be, 0);
        check("ready_eq_done", r_err[k] - base_re, 0);
        for (int b = 0; b < 256; b++) begin
            exp = (v.hot == b) ? 32'(v.hot_val) : 32'(v.other);
            check($sformatf("inst%0d_bin[%0d]", k, b), bmem[k][b], exp);
        end
    endtask

    initial begin
        int waited, base_a, base_b, base_d;
        for (int k = 0; k < 4; k++) start[k] = 1'b0;

        //          inst pat n_in lat  ovf hot hot_val other
        vecs[0] = '{0,   0,  256, 771, 0,  -1, 0,      1};
        vecs[1] = '{0,   1,  256, 771, 0,  42, 256,    0};
        vecs[2] = '{1,   2,  20,  535, 1,  5,  15,     0};
        vecs[3] = '{2,   2,  20,  535, 1,  5,  4,      0};
        vecs[4] = '{3,   0,  256, 771, 0,  -1, 0,      1};
        vecs[5] = '{3,   0,  256, 515, 0,  -1, 0,      2};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("rst_idle", idle_w[k], 1);
            check("rst_done", done_w[k], 0);
            check("rst_ready", ready_w[k], 0);
            check("rst_a_ce", ace_w[k], 0);
            check("rst_a_addr", aaddr_w[k], 0);
            check("rst_b_we", bwe_w[k], 0);
            check("rst_b_addr", baddr_w[k], 0);
            check("rst_b_d", bd_w[k], 0);
            check("rst_ovf", ovf_w[k], 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 6; t++) run_check(vecs[t]);

        // Reset in the middle of READ, at sample index 100.
        load_rom(0, 0);
        base_d = d_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        waited = 0;
        while (!(ace_w[0] && aaddr_w[0] == 8'd100) && waited < 2000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("reached_i100", ace_w[0] && aaddr_w[0] == 8'd100, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_idle", idle_w[0], 1);
        check("midrst_a_ce", ace_w[0], 0);
        check("midrst_a_addr", aaddr_w[0], 0);
        check("midrst_b_we", bwe_w[0], 0);
        check("midrst_done", done_w[0], 0);
        check("midrst_ovf", ovf_w[0], 0);
        #1;
        base_a = a_cnt[0];
        base_b = b_cnt[0];
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_a", a_cnt[0] - base_a, 0);
        check("midrst_no_b", b_cnt[0] - base_b, 0);
        check("midrst_no_done", d_cnt[0] - base_d, 0);
        run_check(vecs[1]);

        // ap_start pulsed during DUMP is ignored.
        load_rom(0, 0);
        base_a = a_cnt[0];
        base_d = d_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        waited = 0;
        while (!bwe_w[0] && waited < 2000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("reached_dump", bwe_w[0], 1);
        start[0] = 1'b1;
        @(negedge clk);
        #1;
        start[0] = 1'b0;
        waited = 0;
        while (d_cnt[0] == base_d && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        repeat (40) @(posedge clk);
        #1;
        check("dump_start_one_done", d_cnt[0] - base_d, 1);
        check("dump_start_a_reads", a_cnt[0] - base_a, 256);
        check("dump_start_idle", idle_w[0], 1);
        check("dump_start_bin7", bmem[0][7], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
